prbs15_pattern_gen: RTL and testbench

Stimulus source that sits directly upstream of the pattern detector and drives its out_PRBS byte bus.
- On a start pulse it emits a 32-bit pattern, MSB byte first, repeated N times.
- It then emits a fixed-length stream of PRBS-15 bytes and returns to idle.
- The detector's n_detec is tied to the same N, so the detector sees the pattern bursts followed by pseudo-random data.

---
 rtl/prbs15_pattern_gen_if.sv | 46 ++++
 rtl/prbs15_pattern_gen.sv | 199 +++++++++++++++++++
 tb/tb_prbs15_pattern_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/prbs15_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : prbs15_pattern_gen_if
//  Purpose  : Request/stream bundle between a sequencer (master) and the
//             PRBS-15 pattern generator (slave).
//  Signals  : start    - single-cycle request to begin a sequence
//             pattern  - 32-bit pattern word, latched on an accepted start
//             n_rep    - pattern repetition count, latched on accepted start
//             out_PRBS - byte stream towards the pattern detector
//             out_valid- out_PRBS carries a valid byte
//             busy     - generator is not idle
//             done     - one-cycle pulse after the last PRBS byte
//  Revision : 1.0  initial release
// ============================================================================
interface prbs15_pattern_gen_if;
  logic        start;
  logic [31:0] pattern;
  logic [7:0]  n_rep;
  logic [7:0]  out_PRBS;
  logic        out_valid;
  logic        busy;
  logic        done;

  // Requesting side: drives the request, observes the stream.
  modport master (
    output start,
    output pattern,
    output n_rep,
    input  out_PRBS,
    input  out_valid,
    input  busy,
    input  done
  );

  // Generator side.
  modport slave (
    input  start,
    input  pattern,
    input  n_rep,
    output out_PRBS,
    output out_valid,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/prbs15_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : prbs15_pattern_gen
//  Purpose  : Stimulus source for the pattern detector. On an accepted start
//             it emits a latched 32-bit pattern (MSB byte first) n_rep times,
//             followed by PRBS_BYTES bytes of PRBS-15 (x^15+x^14+1) data,
//             then pulses done for one cycle and returns to idle.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous, active-high reset
//             bus  - prbs15_pattern_gen_if.slave (start, pattern, n_rep in;
//                    out_PRBS, out_valid, busy, done out; all registered)
//  Params   : PRBS_SEED  - LFSR load value on every start (non-zero)
//             PRBS_BYTES - PRBS bytes emitted after the pattern phase
//  Revision : 1.0  initial release
// ============================================================================
module prbs15_pattern_gen #(
  parameter logic [14:0] PRBS_SEED  = 15'h7FFF,
  parameter logic [15:0] PRBS_BYTES = 16'd16
) (
  input  logic                        clk,
  input  logic                        rst,
  prbs15_pattern_gen_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PATTERN = 2'd1,
    PRBS    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers (_q) with their next values (_d)
  // --------------------------------------------------------------------------
  state_t      state_q,   state_d;
  logic [31:0] pat_q,     pat_d;
  logic [7:0]  nrep_q,    nrep_d;
  logic [1:0]  idx_q,     idx_d;
  logic [7:0]  rep_q,     rep_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [14:0] lfsr_q,    lfsr_d;
  logic [7:0]  out_q,     out_d;
  logic        valid_q,   valid_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  // --------------------------------------------------------------------------
  // Eight LFSR bit-steps unrolled into one clock. Each step's feedback bit is
  // also the output bit; shifting it in from the LSB leaves the first
  // generated bit in position 7 after eight steps.
  // --------------------------------------------------------------------------
  function automatic logic [22:0] lfsr_step8(input logic [14:0] r_in);
    logic [14:0] r;
    logic [7:0]  b;
    logic        fb;
    r = r_in;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb = r[14] ^ r[13];
      r  = {r[13:0], fb};
      b  = {b[6:0], fb};
    end
    return {r, b};
  endfunction

  logic [14:0] lfsr_next;
  logic [7:0]  prbs_byte;

  assign {lfsr_next, prbs_byte} = lfsr_step8(lfsr_q);

  // Byte of the latched pattern selected by the byte index, MSB byte first.
  logic [7:0] pat_byte;

  always_comb begin
    pat_byte = 8'h00;
    case (idx_q)
      2'd0:    pat_byte = pat_q[31:24];
      2'd1:    pat_byte = pat_q[23:16];
      2'd2:    pat_byte = pat_q[15:8];
      default: pat_byte = pat_q[7:0];
    endcase
  end

  // Last pattern byte: index at 3 and rep counter at n_rep-1. n_rep=0 never
  // enters PATTERN, so the subtraction cannot underflow here.
  logic last_pat_byte;
  assign last_pat_byte = (idx_q == 2'd3) && (rep_q == (nrep_q - 8'd1));

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    nrep_d  = nrep_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    out_d   = 8'h00;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          pat_d   = bus.pattern;
          nrep_d  = bus.n_rep;
          lfsr_d  = PRBS_SEED;
          idx_d   = 2'd0;
          rep_d   = 8'd0;
          cnt_d   = 16'd0;
          busy_d  = 1'b1;
          state_d = (bus.n_rep != 8'd0) ? PATTERN : PRBS;
        end
      end

      PATTERN: begin
        out_d   = pat_byte;
        valid_d = 1'b1;
        if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          rep_d = rep_q + 8'd1;
          if (last_pat_byte) begin
            state_d = PRBS;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      PRBS: begin
        // The cycle after the final PRBS byte issues the done pulse, so that
        // the DONE state coincides with done being visible on the outputs
        // and a start in that cycle is ignored.
        if (cnt_q == PRBS_BYTES) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          out_d   = prbs_byte;
          valid_d = 1'b1;
          lfsr_d  = lfsr_next;
          cnt_d   = cnt_q + 16'd1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= 32'h0000_0000;
      nrep_q  <= 8'd0;
      idx_q   <= 2'd0;
      rep_q   <= 8'd0;
      cnt_q   <= 16'd0;
      lfsr_q  <= PRBS_SEED;
      out_q   <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      nrep_q  <= nrep_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_PRBS  = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs15_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs15_pattern_gen
//  Purpose  : Self-checking bench for prbs15_pattern_gen. Expected bytes are
//             queued when a start is driven and popped as valid bytes appear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prbs15_pattern_gen;

  localparam logic [14:0] SEED   = 15'h7FFF;
  localparam int          NBYTES = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prbs15_pattern_gen_if bus ();

  prbs15_pattern_gen #(
    .PRBS_SEED  (SEED),
    .PRBS_BYTES (16'(NBYTES))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  logic [7:0] prev[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pattern bytes then PRBS-15 bytes from the seed.
  task automatic push_expected(input logic [31:0] pat, input int n);
    logic [14:0] r;
    logic [7:0]  b;
    logic        fb;
    for (int rep = 0; rep < n; rep++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back(pat[31-8*k -: 8]);
    r = SEED;
    for (int k = 0; k < NBYTES; k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        fb = r[14] ^ r[13];
        r  = {r[13:0], fb};
        b  = {b[6:0], fb};
      end
      exp_q.push_back(b);
    end
  endtask

  // Behavioural stand-in for the downstream detector with n_detec = n.
  function automatic bit detect(input logic [31:0] w, input int n);
    if (seen.size() < 4*n) return 1'b0;
    for (int i = 0; i < 4*n; i++)
      if (seen[i] !== w[31-8*(i%4) -: 8]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_seq(input logic [31:0] pat, input logic [7:0] n,
                         input bit repulse, input int rst_at);
    int cnt       = 0;
    int prbs_seen = 0;
    bit fin       = 1'b0;
    bit aborted   = 1'b0;
    bit fired     = 1'b0;
    seen.delete();
    exp_q.delete();
    push_expected(pat, int'(n));

    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.n_rep   = n;
    @(negedge clk);
    bus.start = 1'b0;
    check_val("accept_busy", 32'(bus.busy), 32'd1);
    check_val("latency_no_valid", 32'(bus.out_valid), 32'd0);

    for (int cyc = 0; cyc < 1200 && !fin; cyc++) begin
      @(negedge clk);
      if (bus.start) bus.start = 1'b0;
      if (cyc == 0) check_val("first_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) begin
        seen.push_back(bus.out_PRBS);
        if (exp_q.size() == 0) check_val("byte_count_over", cnt + 1, 4*n + NBYTES);
        else check_val("byte", 32'(bus.out_PRBS), 32'(exp_q.pop_front()));
        cnt++;
        if (cnt > 4*n) prbs_seen++;
        if (rst_at > 0 && prbs_seen == rst_at) begin
          #2 rst = 1'b1;
          #1;
          check_val("rst_valid", 32'(bus.out_valid), 32'd0);
          check_val("rst_busy", 32'(bus.busy), 32'd0);
          check_val("rst_data", 32'(bus.out_PRBS), 32'd0);
          check_val("rst_done", 32'(bus.done), 32'd0);
          aborted = 1'b1;
          fin     = 1'b1;
        end
      end
      if (!aborted && bus.done) begin
        check_val("done_busy", 32'(bus.busy), 32'd0);
        check_val("done_valid", 32'(bus.out_valid), 32'd0);
        check_val("done_data", 32'(bus.out_PRBS), 32'd0);
        fin = 1'b1;
      end
      if (repulse && !fired && cnt == 2) begin
        bus.start   = 1'b1;
        bus.pattern = 32'h1111_1111;
        bus.n_rep   = 8'd7;
        fired       = 1'b1;
      end
    end

    check_val("timeout", 32'(fin), 32'd1);
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
    end else begin
      check_val("byte_count", cnt, 4*n + NBYTES);
      check_val("leftover", exp_q.size(), 32'd0);
      @(negedge clk);
      check_val("done_one_cycle", 32'(bus.done), 32'd0);
      check_val("idle_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = 32'h0;
    bus.n_rep   = 8'd0;

    // Reset asserted mid-clock
    #2 rst = 1'b1;
    #1;
    check_val("reset_valid", 32'(bus.out_valid), 32'd0);
    check_val("reset_busy", 32'(bus.busy), 32'd0);
    check_val("reset_done", 32'(bus.done), 32'd0);
    check_val("reset_data", 32'(bus.out_PRBS), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single repetition
    run_seq(32'hABCDEF23, 8'd1, 1'b0, 0);
    check_val("flag_n1", 32'(detect(32'hABCDEF23, 1)), 32'd1);

    // Three repetitions; first PRBS bytes from seed 7FFF are 00 then 02
    run_seq(32'hABCDEF23, 8'd3, 1'b0, 0);
    check_val("flag_n3", 32'(detect(32'hABCDEF23, 3)), 32'd1);
    check_val("prbs_first", 32'(seen[12]), 32'h00);
    check_val("prbs_second", 32'(seen[13]), 32'h02);

    // Corrupted pattern is not recognised by the detector
    run_seq(32'hABCDEF24, 8'd3, 1'b0, 0);
    check_val("flag_corrupt", 32'(detect(32'hABCDEF23, 3)), 32'd0);

    // No pattern phase
    run_seq(32'hABCDEF23, 8'd0, 1'b0, 0);
    check_val("n0_first", 32'(seen[0]), 32'h00);

    // Start re-pulsed (with new pattern/n_rep) during PATTERN is ignored
    run_seq(32'h5A3C_96E1, 8'd2, 1'b1, 0);

    // Reset at the 5th PRBS byte, then a fresh start replays the stream
    run_seq(32'hABCDEF23, 8'd1, 1'b0, 5);
    prev = seen;
    run_seq(32'hABCDEF23, 8'd1, 1'b0, 0);
    for (int k = 0; k < prev.size(); k++)
      check_val("replay", 32'(seen[k]), 32'(prev[k]));

    // Maximum repetition count
    run_seq(32'hDEADBEEF, 8'd255, 1'b0, 0);
    check_val("flag_n255", 32'(detect(32'hDEADBEEF, 255)), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
